// File: rtl/nco_sweep_ctrl_if.sv
// Control-side bus of the NCO sweep controller.
//   cfg_we/cfg_addr/cfg_wdata : register write port (0=f_start 1=f_stop 2=f_step 3=dwell)
//   start / abort             : single-cycle sweep request / cancel
// master = host driving the controller, slave = nco_sweep_ctrl.
interface nco_sweep_ctrl_if #(parameter int apr = 32);
  logic           cfg_we;
  logic [1:0]     cfg_addr;
  logic [apr-1:0] cfg_wdata;
  logic           start;
  logic           abort;

  modport master (output cfg_we, cfg_addr, cfg_wdata, start, abort);
  modport slave  (input  cfg_we, cfg_addr, cfg_wdata, start, abort);
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep controller for a streaming NCO.
// Steps phi_inc_o from f_start toward f_stop by f_step, holding each value for
// dwell+1 cycles, then keeps the NCO clocked for nco_lat cycles so the last
// samples drain out, pulses done and returns to IDLE.
// Ports:
//   clk, reset_n   : clock, async active-low reset
//   ctl            : config write port + start/abort (nco_sweep_ctrl_if.slave)
//   nco_out_valid  : NCO out_valid
//   phi_inc_o      : NCO phase increment
//   nco_clken      : NCO clock enable
//   busy           : high in SWEEP and DRAIN
//   done           : one-cycle pulse on the last DRAIN cycle
//   sweep_valid    : NCO sample belongs to the current sweep
module nco_sweep_ctrl #(
  parameter int apr     = 32,
  parameter int dwr     = 16,
  parameter int nco_lat = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  nco_sweep_ctrl_if.slave ctl,
  input  logic           nco_out_valid,
  output logic [apr-1:0] phi_inc_o,
  output logic           nco_clken,
  output logic           busy,
  output logic           done,
  output logic           sweep_valid
);

  localparam int CW = $clog2(nco_lat + 1);
  localparam logic [CW-1:0] LAT    = CW'(nco_lat);
  localparam logic [CW-1:0] LAT_M1 = CW'(nco_lat - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]     state, state_n;
  logic [apr-1:0] f_start, f_stop, f_step;
  logic [dwr-1:0] dwell, dcnt, dcnt_n;
  logic [CW-1:0]  dr_cnt, dr_n;   // DRAIN cycles remaining after the current one
  logic [CW-1:0]  vcnt, vcnt_n;   // clken cycles since start, saturates at nco_lat
  logic [apr-1:0] phi_n;
  logic           clken_n, busy_n, done_n;

  // Extra carry bit so a step past the top of the range clamps instead of wrapping.
  logic [apr:0]   sum;
  logic [apr-1:0] step_f;

  assign sum = {1'b0, phi_inc_o} + {1'b0, f_step};

  always_comb begin
    // f_step=0 jumps straight to f_stop so the sweep always terminates.
    if (f_step == '0 || sum[apr] || sum[apr-1:0] > f_stop) step_f = f_stop;
    else                                                  step_f = sum[apr-1:0];
  end

  always_comb begin
    state_n = state;
    phi_n   = phi_inc_o;
    clken_n = nco_clken;
    busy_n  = busy;
    done_n  = 1'b0;
    dcnt_n  = dcnt;
    dr_n    = dr_cnt;
    if (ctl.abort) begin
      state_n = S_IDLE;
      clken_n = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        S_IDLE: if (ctl.start) begin
          state_n = S_SWEEP;
          phi_n   = f_start;
          clken_n = 1'b1;
          busy_n  = 1'b1;
          dcnt_n  = dwell;
        end
        S_SWEEP: begin
          if (dcnt != '0) dcnt_n = dcnt - 1'b1;
          else if (phi_inc_o >= f_stop) begin
            state_n = S_DRAIN;
            dr_n    = LAT_M1;
            done_n  = (nco_lat == 1);
          end else begin
            phi_n  = step_f;
            dcnt_n = dwell;
          end
        end
        S_DRAIN: begin
          if (dr_cnt == '0) begin
            state_n = S_IDLE;
            clken_n = 1'b0;
            busy_n  = 1'b0;
          end else begin
            dr_n   = dr_cnt - 1'b1;
            done_n = (dr_cnt == CW'(1));
          end
        end
        default: begin
          state_n = S_IDLE;
          clken_n = 1'b0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    vcnt_n = vcnt;
    if (state == S_IDLE && ctl.start && !ctl.abort) vcnt_n = '0;
    else if (nco_clken && vcnt != LAT)              vcnt_n = vcnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      phi_inc_o   <= '0;
      nco_clken   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sweep_valid <= 1'b0;
      dcnt        <= '0;
      dr_cnt      <= '0;
      vcnt        <= '0;
    end else begin
      state       <= state_n;
      phi_inc_o   <= phi_n;
      nco_clken   <= clken_n;
      busy        <= busy_n;
      done        <= done_n;
      dcnt        <= dcnt_n;
      dr_cnt      <= dr_n;
      vcnt        <= vcnt_n;
      // Evaluated on next-state values so it drops together with busy.
      sweep_valid <= nco_out_valid && busy_n && (vcnt_n >= LAT);
    end
  end

  // Configuration is frozen while a sweep is in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      f_start <= '0;
      f_stop  <= '0;
      f_step  <= '0;
      dwell   <= '0;
    end else if (ctl.cfg_we && state == S_IDLE) begin
      case (ctl.cfg_addr)
        2'd0:    f_start <= ctl.cfg_wdata;
        2'd1:    f_stop  <= ctl.cfg_wdata;
        2'd2:    f_step  <= ctl.cfg_wdata;
        default: dwell   <= ctl.cfg_wdata[dwr-1:0];
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
module tb_nco_sweep_ctrl;
  localparam int APR = 32;
  localparam int DWR = 16;
  localparam int LAT = 10;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           nco_out_valid = 1'b1;
  logic [APR-1:0] phi_inc_o;
  logic           nco_clken, busy, done, sweep_valid;

  nco_sweep_ctrl_if #(.apr(APR)) ctl ();

  nco_sweep_ctrl #(.apr(APR), .dwr(DWR), .nco_lat(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .ctl(ctl.slave), .nco_out_valid(nco_out_valid),
    .phi_inc_o(phi_inc_o), .nco_clken(nco_clken), .busy(busy), .done(done),
    .sweep_valid(sweep_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [APR-1:0] phi;
    bit             done;
    int             k;      // 1-based cycle index since start
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0;
  int          busy_cnt = 0, done_cnt = 0;
  bit          rnd_nov = 1'b0;
  bit          nov_prev = 1'b1;
  logic [63:0] m_start = 0, m_stop = 0, m_step = 0, m_dwell = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference sweep: list of frequencies from the rules, each held dwell+1 cycles,
  // then nco_lat drain cycles with done on the last one.
  task automatic push_sweep();
    logic [63:0] f;
    int k;
    exp_t e;
    f = m_start;
    k = 1;
    forever begin
      for (int d = 0; d <= int'(m_dwell); d++) begin
        e.phi = f[APR-1:0]; e.done = 1'b0; e.k = k++; q.push_back(e);
      end
      if (f >= m_stop) break;
      if (m_step == 0 || f + m_step > m_stop) f = m_stop;
      else f = f + m_step;
    end
    for (int d = 1; d <= LAT; d++) begin
      e.phi = f[APR-1:0]; e.done = (d == LAT); e.k = k++; q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      busy_cnt++;
      if (q.size() == 0) chk("unexpected_busy", 1, 0);
      else begin
        e = q.pop_front();
        chk("phi_inc_o", phi_inc_o, e.phi);
        chk("nco_clken_busy", nco_clken, 1);
        chk("done", done, e.done);
        chk("sweep_valid", sweep_valid, nov_prev && (e.k > LAT));
      end
    end else begin
      if (q.size() != 0) begin
        chk("early_end_left", q.size(), 0);
        q.delete();
      end
      chk("idle_clken", nco_clken, 0);
      chk("idle_done", done, 0);
      chk("idle_sweep_valid", sweep_valid, 0);
    end
    if (done) done_cnt++;
    nov_prev = nco_out_valid;
  end

  initial forever begin
    @(posedge clk);
    #1 nco_out_valid = rnd_nov ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Writes are only issued from here while idle, so the model always takes them.
  task automatic write_cfg(input logic [1:0] a, input logic [APR-1:0] d);
    ctl.cfg_we = 1'b1; ctl.cfg_addr = a; ctl.cfg_wdata = d;
    @(posedge clk); #1;
    ctl.cfg_we = 1'b0;
    case (a)
      2'd0: m_start = 64'(d);
      2'd1: m_stop  = 64'(d);
      2'd2: m_step  = 64'(d);
      default: m_dwell = 64'(d[DWR-1:0]);
    endcase
  endtask

  task automatic set_cfg(input logic [APR-1:0] s, input logic [APR-1:0] p,
                         input logic [APR-1:0] st, input logic [APR-1:0] dw);
    write_cfg(2'd0, s); write_cfg(2'd1, p); write_cfg(2'd2, st); write_cfg(2'd3, dw);
  endtask

  task automatic pulse_start();
    ctl.start = 1'b1;
    @(posedge clk); #1;
    ctl.start = 1'b0;
    push_sweep();
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000 && (q.size() != 0 || busy); i++) @(posedge clk);
    #1;
    if (i >= 3000) begin
      chk("wait_idle_timeout", 1, 0);
      q.delete();
    end
  endtask

  initial begin
    ctl.cfg_we = 1'b0; ctl.cfg_addr = '0; ctl.cfg_wdata = '0;
    ctl.start = 1'b0; ctl.abort = 1'b0;
    #12;
    chk("rst_phi", phi_inc_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clken", nco_clken, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Basic sweep: 100,110,120,130 x3, then drain.
    set_cfg(100, 130, 10, 2);
    busy_cnt = 0; done_cnt = 0;
    pulse_start();
    wait_idle();
    repeat (2) @(posedge clk); #1;
    chk("basic_busy_cycles", busy_cnt, 22);
    chk("basic_done_count", done_cnt, 1);

    // Clamp to f_stop.
    set_cfg(100, 125, 10, 0);
    pulse_start(); wait_idle();

    // Zero step.
    set_cfg(100, 200, 0, 1);
    pulse_start(); wait_idle();

    // Top of range, no wrap.
    set_cfg(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0);
    pulse_start(); wait_idle();

    // f_start >= f_stop: single dwell.
    set_cfg(300, 200, 5, 2);
    pulse_start(); wait_idle();

    // Abort in 4th sweep cycle; write and start during sweep are ignored.
    set_cfg(100, 130, 10, 2);
    busy_cnt = 0; done_cnt = 0;
    pulse_start();                       // now in sweep cycle 1
    ctl.cfg_we = 1'b1; ctl.cfg_addr = 2'd0; ctl.cfg_wdata = 999; ctl.start = 1'b1;
    @(posedge clk); #1;                  // cycle 2
    ctl.cfg_we = 1'b0; ctl.start = 1'b0;
    @(posedge clk); #1;                  // cycle 3
    @(posedge clk); #1;                  // cycle 4
    ctl.abort = 1'b1;
    @(posedge clk); #1;
    ctl.abort = 1'b0;
    q.delete();
    chk("abort_busy", busy, 0);
    chk("abort_clken", nco_clken, 0);
    repeat (3) @(posedge clk); #1;
    chk("abort_busy_cycles", busy_cnt, 4);
    chk("abort_no_done", done_cnt, 0);

    // Abort together with start in idle: nothing starts.
    ctl.abort = 1'b1; ctl.start = 1'b1;
    @(posedge clk); #1;
    ctl.abort = 1'b0; ctl.start = 1'b0;
    @(posedge clk); #1;
    chk("abort_start_busy", busy, 0);

    // f_start must still be 100.
    pulse_start(); wait_idle();

    // Reset mid-DRAIN is asynchronous; config returns to 0.
    done_cnt = 0;
    pulse_start();
    repeat (14) @(posedge clk);
    #3 reset_n = 1'b0;
    q.delete();
    m_start = 0; m_stop = 0; m_step = 0; m_dwell = 0;
    #1;
    chk("arst_phi", phi_inc_o, 0);
    chk("arst_busy", busy, 0);
    chk("arst_clken", nco_clken, 0);
    chk("arst_done", done, 0);
    chk("arst_sv", sweep_valid, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_no_done", done_cnt, 0);
    pulse_start(); wait_idle();

    // Random sweeps with random nco_out_valid.
    rnd_nov = 1'b1;
    for (int n = 0; n < 12; n++) begin
      logic [APR-1:0] s, p, st;
      s  = 32'($urandom_range(0, 400));
      p  = 32'($urandom_range(0, 400));
      st = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 80));
      if (n == 11) begin
        s = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
        p = 32'hFFFF_FFFF;
        st = 32'hFFFF_0000;
      end
      set_cfg(s, p, st, 32'($urandom_range(0, 3)));
      pulse_start(); wait_idle();
      @(posedge clk); #1;
    end
    rnd_nov = 1'b0;

    repeat (3) @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end
endmodule
